// File: rtl/alarm_event_reporter.sv
// alarm_event_reporter
//
// Far-end companion to the sensor/buzzer alarm core. Watches the eight buzzer
// lines, turns every new activation (rising edge) into an event byte, queues
// the bytes in a small FIFO and sends each one as a UART-style frame on a
// single wire (start bit low, 8 data bits LSB first, stop bit high).
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   FIFO_DEPTH    event FIFO entries (power of 2, >= 2)
//
// Ports
//   clk         system clock
//   rst_n       asynchronous reset, active-low (synchronous release expected)
//   ena         block enable; 0 blocks new event capture
//   buzz_in     buzzer lines from the alarm core, asynchronous to clk
//   tx_out      serial report line, idles high, registered
//   busy        1 while a frame is being transmitted
//   overflow    sticky: an event was dropped because the FIFO was full
//   fifo_level  queued events, not counting the frame in flight

module alarm_event_reporter #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [7:0]                    buzz_in,
  output logic                          tx_out,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  // --------------------------------------------------------------------------
  // Input path: two-flop synchronizer plus an edge register
  // --------------------------------------------------------------------------
  logic [7:0] s1_q, s2_q, s3_q;
  logic [7:0] rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= buzz_in;
      s2_q <= s1_q;
      // Keeps tracking while ena=0, so lines that rose while disabled are
      // already "seen" and never report later.
      s3_q <= s2_q;
    end
  end

  // Clearing s3 at reset makes a line held high across reset release look
  // like a fresh rise, which is intended.
  assign rise = s2_q & ~s3_q;

  // --------------------------------------------------------------------------
  // Event FIFO
  // --------------------------------------------------------------------------
  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // and the level is a plain difference.
  logic [LvlW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LvlW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [LvlW-1:0] level;
  logic            empty;
  logic            full;
  logic [7:0]      head;

  logic            push_req;
  logic            push;
  logic            pop;
  logic            ovf_q, ovf_d;

  assign level    = wr_ptr_q - rd_ptr_q;
  assign empty    = (level == '0);
  assign full     = (level == LvlFull);
  assign head     = mem_q[rd_ptr_q[PtrW-1:0]];

  assign push_req = ena && (rise != 8'h00);
  // A pop in the same cycle frees the head slot, so a push onto a full FIFO
  // is still accepted; the head is read before the write lands.
  assign push     = push_req && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + LvlW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + LvlW'(1);
    end
    if (push_req && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: emptiness is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= rise;
    end
  end

  // --------------------------------------------------------------------------
  // Transmitter FSM
  // --------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            cnt_last;

  assign cnt_last = (cnt_q == CntLast);

  // tx_d is the line level for the cycle the FSM is entering, so tx_q changes
  // on the same edge as the state and stays glitch-free.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          cnt_d   = '0;
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end

      StStart: begin
        if (cnt_last) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = StData;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StData: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StStop: begin
        tx_d = 1'b1;
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign tx_out     = tx_q;
  assign busy       = (state_q != StIdle);
  assign overflow   = ovf_q;
  assign fifo_level = level;

endmodule
